// File: rtl/gcd_sub_param.sv
// ---------------------------------------------------------------------------
// gcd_sub_param
// Repeated-subtraction GCD engine with a start/ready/done handshake.
// A single FSM drives an internal A/B register pair, one comparator and one
// subtractor. Zero operands finish immediately with gcd = a_in | b_in.
//
// Optional macro: GCD_ITER_CNT_EN adds the iter_cnt port and a saturating
// subtraction counter. Without the macro, that port and its logic are absent.
//
// Parameters:
//   WIDTH  operand/result width (>= 2)
//   CNT_W  iteration counter width (used only with GCD_ITER_CNT_EN)
//
// Ports:
//   clock     system clock, posedge
//   reset     synchronous, active-high
//   start     request, sampled only while ready
//   a_in      operand A, captured on an accepted start
//   b_in      operand B, captured on an accepted start
//   ready     high in IDLE and DONE
//   busy      high in CALC
//   done      one-cycle completion pulse (DONE state)
//   gcd_out   result, held until the next accepted start completes
//   iter_cnt  subtraction count (GCD_ITER_CNT_EN only)
// ---------------------------------------------------------------------------
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for start; ready=1
// S_CALC | one compare and at most one subtraction per cycle; busy=1
// S_DONE | result valid; done=1, ready=1 (back-to-back start allowed)
// ---------------------------------------------------------------------------
module gcd_sub_param #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic             ready,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] gcd_out
`ifdef GCD_ITER_CNT_EN
   ,
   output logic [CNT_W-1:0] iter_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] gcd_q, gcd_d;
   logic             accept;
   logic             a_eq_b;
   logic             a_gt_b;

   assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
   assign busy   = (state_q == S_CALC);
   assign done   = (state_q == S_DONE);
   assign accept = ready && start;

   assign a_eq_b = (a_q == b_q);
   assign a_gt_b = (a_q > b_q);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         gcd_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         gcd_q   <= gcd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      gcd_d   = gcd_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (start) begin
               a_d = a_in;
               b_d = b_in;
               // gcd(x,0) = x and gcd(0,0) = 0 both reduce to a bitwise OR
               if ((a_in == '0) || (b_in == '0)) begin
                  gcd_d   = a_in | b_in;
                  state_d = S_DONE;
               end else begin
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            // both operands stay nonzero here, so neither subtraction wraps
            if (a_eq_b) begin
               gcd_d   = a_q;
               state_d = S_DONE;
            end else if (a_gt_b) begin
               a_d = a_q - b_q;
            end else begin
               b_d = b_q - a_q;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign gcd_out = gcd_q;

`ifdef GCD_ITER_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (accept) begin
         cnt_d = '0;
      end else if ((state_q == S_CALC) && !a_eq_b && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign iter_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_gcd_sub_param.sv
module tb_gcd_sub_param;

   logic clock = 1'b0;
   logic reset = 1'b1;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   // 16-bit instance
   logic        start16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic        ready16, busy16, done16;
   logic [15:0] gcd16;
   // 8-bit instances, shared inputs, CNT_W = 4 and CNT_W = 8
   logic        start8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        ready8, busy8, done8, ready8w, busy8w, done8w;
   logic [7:0]  gcd8, gcd8w;
   // 32-bit instance
   logic        start32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic        ready32, busy32, done32;
   logic [31:0] gcd32;
`ifdef GCD_ITER_CNT_EN
   logic [15:0] iter16;
   logic [3:0]  iter8;
   logic [7:0]  iter8w;
   logic [15:0] iter32;
`endif

   gcd_sub_param #(.WIDTH(16), .CNT_W(16)) dut16 (
      .clock(clock), .reset(reset), .start(start16), .a_in(a16), .b_in(b16),
      .ready(ready16), .busy(busy16), .done(done16), .gcd_out(gcd16)
`ifdef GCD_ITER_CNT_EN
      , .iter_cnt(iter16)
`endif
   );

   gcd_sub_param #(.WIDTH(8), .CNT_W(4)) dut8 (
      .clock(clock), .reset(reset), .start(start8), .a_in(a8), .b_in(b8),
      .ready(ready8), .busy(busy8), .done(done8), .gcd_out(gcd8)
`ifdef GCD_ITER_CNT_EN
      , .iter_cnt(iter8)
`endif
   );

   gcd_sub_param #(.WIDTH(8), .CNT_W(8)) dut8w (
      .clock(clock), .reset(reset), .start(start8), .a_in(a8), .b_in(b8),
      .ready(ready8w), .busy(busy8w), .done(done8w), .gcd_out(gcd8w)
`ifdef GCD_ITER_CNT_EN
      , .iter_cnt(iter8w)
`endif
   );

   gcd_sub_param #(.WIDTH(32), .CNT_W(16)) dut32 (
      .clock(clock), .reset(reset), .start(start32), .a_in(a32), .b_in(b32),
      .ready(ready32), .busy(busy32), .done(done32), .gcd_out(gcd32)
`ifdef GCD_ITER_CNT_EN
      , .iter_cnt(iter32)
`endif
   );

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Counts edges until done16 is seen (bounded), plus busy cycles on the way.
   task automatic wait16(output int lat, output int nbusy);
      lat = 0;
      nbusy = 0;
      while (!done16 && lat < 300) begin
         if (busy16) nbusy++;
         tick();
         lat++;
      end
   endtask

   // Accept on one edge, then wait for done.
   task automatic run16(input logic [15:0] a, input logic [15:0] b, output int lat, output int nbusy);
      a16 = a;
      b16 = b;
      start16 = 1'b1;
      tick();
      start16 = 1'b0;
      wait16(lat, nbusy);
   endtask

   initial begin
      int lat, nbusy;

      // reset
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check("rst_ready", ready16, 1);
      check("rst_busy",  busy16,  0);
      check("rst_done",  done16,  0);
      check("rst_gcd",   gcd16,   0);
`ifdef GCD_ITER_CNT_EN
      check("rst_iter", iter16, 0);
`endif

      // 143,78 -> 13, S=6, done after edge t0+7, busy 7 cycles
      run16(16'd143, 16'd78, lat, nbusy);
      check("t1_lat",  lat,   7);
      check("t1_busy", nbusy, 7);
      check("t1_gcd",  gcd16, 13);
`ifdef GCD_ITER_CNT_EN
      check("t1_iter", iter16, 6);
`endif
      tick();
      check("t1_done_one_cycle", done16, 0);
      check("t1_idle_ready", ready16, 1);
      check("t1_gcd_held", gcd16, 13);

      // equal operands
      run16(16'd42, 16'd42, lat, nbusy);
      check("t2_eq_lat", lat, 1);
      check("t2_eq_gcd", gcd16, 42);
`ifdef GCD_ITER_CNT_EN
      check("t2_eq_iter", iter16, 0);
`endif
      tick();
      // zero operand: done in the cycle right after accept
      run16(16'd0, 16'd25, lat, nbusy);
      check("t2_zero_lat", lat, 0);
      check("t2_zero_gcd", gcd16, 25);
`ifdef GCD_ITER_CNT_EN
      check("t2_zero_iter", iter16, 0);
`endif
      tick();
      run16(16'd0, 16'd0, lat, nbusy);
      check("t2_zz_lat", lat, 0);
      check("t2_zz_gcd", gcd16, 0);
      tick();

      // start while busy is ignored, then back-to-back from DONE
      a16 = 16'd143;
      b16 = 16'd78;
      start16 = 1'b1;
      tick();
      start16 = 1'b0;
      tick();
      tick();
      a16 = 16'd9;
      b16 = 16'd6;
      start16 = 1'b1;
      tick();
      start16 = 1'b0;
      check("t3_still_busy", busy16, 1);
      wait16(lat, nbusy);
      check("t3_ign_lat", lat, 4);
      check("t3_ign_gcd", gcd16, 13);
      a16 = 16'd9;
      b16 = 16'd6;
      start16 = 1'b1;
      tick();
      start16 = 1'b0;
      check("t3_b2b_busy",  busy16,  1);
      check("t3_b2b_ready", ready16, 0);
      wait16(lat, nbusy);
      check("t3_b2b_lat", lat, 3);
      check("t3_b2b_gcd", gcd16, 3);
`ifdef GCD_ITER_CNT_EN
      check("t3_b2b_iter", iter16, 2);
`endif
      tick();

      // reset mid-CALC
      a16 = 16'd143;
      b16 = 16'd78;
      start16 = 1'b1;
      tick();
      start16 = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t4_ready", ready16, 1);
      check("t4_busy",  busy16,  0);
      check("t4_done",  done16,  0);
      check("t4_gcd",   gcd16,   0);
`ifdef GCD_ITER_CNT_EN
      check("t4_iter", iter16, 0);
`endif
      tick();
      check("t4_no_done", done16, 0);
      run16(16'd143, 16'd78, lat, nbusy);
      check("t4_rerun_lat", lat, 7);
      check("t4_rerun_gcd", gcd16, 13);

      // 8-bit: 255,1 -> S=254, done after edge t0+255
      a8 = 8'd255;
      b8 = 8'd1;
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      lat = 0;
      while (!done8 && lat < 400) begin
         tick();
         lat++;
      end
      check("t5_lat",      lat,    255);
      check("t5_gcd",      gcd8,   1);
      check("t5_done_w",   done8w, 1);
      check("t5_gcd_w",    gcd8w,  1);
`ifdef GCD_ITER_CNT_EN
      check("t5_iter_sat", iter8,  15);
      check("t5_iter_w",   iter8w, 254);
`endif
      tick();

      // 32-bit: 1000000,1000 -> 1000, S=999
      a32 = 32'h000F_4240;
      b32 = 32'h0000_03E8;
      start32 = 1'b1;
      tick();
      start32 = 1'b0;
      lat = 0;
      while (!done32 && lat < 1200) begin
         tick();
         lat++;
      end
      check("t6_lat", lat,   1000);
      check("t6_gcd", gcd32, 1000);
      tick();
      check("t6_idle", ready32, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
